// File: rtl/ssd_ready_arb.sv
// ssd_ready_arb: per-channel ready with hysteresis and off-time, plus a round-robin bus grant with release gap
module ssd_ready_arb #(
  parameter int CH    = 4,
  parameter int LW    = 11,
  parameter int HI_TH = 1000,
  parameter int LO_TH = 768,
  parameter int HOLD  = 16,
  parameter int HW    = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [CH*LW-1:0] fifo_level,
  input  logic [CH-1:0]    fifo_full_h,
  input  logic [CH-1:0]    ssd_oe,
  input  logic             xfer_done,
  output logic [CH-1:0]    ssd_oe_out,
  output logic [CH-1:0]    ssd_ready,
  output logic [CH-1:0]    grant,
  output logic             grant_valid
);
  localparam int PW = $clog2(CH);
  localparam logic [LW-1:0] HI = LW'(HI_TH);
  localparam logic [LW-1:0] LO = LW'(LO_TH);
  localparam logic [HW-1:0] HLOAD = HW'(HOLD > 0 ? HOLD - 1 : 0);
  typedef enum logic [1:0] {OFF, ON, HLD} ch_st_e;
  typedef enum logic [1:0] {IDLE, GNT, GAP} arb_st_e;
  logic [LW-1:0] level_q [CH];
  logic [CH-1:0] full_q, oe_q;
  ch_st_e        st_q [CH], st_d [CH];
  logic [HW-1:0] cnt_q [CH], cnt_d [CH];
  arb_st_e       ast_q, ast_d;
  logic [CH-1:0] grant_q, grant_d;
  logic [PW-1:0] ptr_q, ptr_d, gidx_q, gidx_d, sel;
  logic          found;
  always_comb begin
    for (int i = 0; i < CH; i++) begin
      st_d[i] = st_q[i];
      cnt_d[i] = cnt_q[i];
      ssd_ready[i] = st_q[i] == ON;
      if (st_q[i] == OFF) begin
        if (oe_q[i] && !full_q[i] && level_q[i] <= LO) st_d[i] = ON;
      end else if (st_q[i] == ON) begin
        if (!oe_q[i] || full_q[i] || level_q[i] >= HI) begin
          st_d[i] = OFF;
          if (HOLD > 0) st_d[i] = HLD;
          cnt_d[i] = HLOAD;
        end
      end else if (cnt_q[i] == '0) begin
        st_d[i] = OFF;
      end else begin
        cnt_d[i] = cnt_q[i] - 1'b1;
      end
    end
  end
  always_comb begin
    found = 1'b0;
    sel = '0;
    for (int j = 0; j < CH; j++) begin
      if (!found && ssd_ready[(int'(ptr_q) + j) % CH]) begin
        found = 1'b1;
        sel = PW'((int'(ptr_q) + j) % CH);
      end
    end
    ast_d = ast_q;
    grant_d = grant_q;
    gidx_d = gidx_q;
    ptr_d = ptr_q;
    if (ast_q == IDLE && found) begin
      ast_d = GNT;
      gidx_d = sel;
      grant_d = CH'(1) << sel;
    end else if (ast_q == GNT && (xfer_done || !ssd_ready[gidx_q])) begin
      ast_d = GAP;
      grant_d = '0;
      ptr_d = (gidx_q == PW'(CH - 1)) ? '0 : gidx_q + 1'b1;
    end else if (ast_q == GAP) begin
      ast_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < CH; i++) begin
        level_q[i] <= '0;
        st_q[i] <= OFF;
        cnt_q[i] <= '0;
      end
      full_q <= '0;
      oe_q <= '0;
      ast_q <= IDLE;
      grant_q <= '0;
      gidx_q <= '0;
      ptr_q <= '0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        level_q[i] <= fifo_level[i*LW +: LW];
        st_q[i] <= st_d[i];
        cnt_q[i] <= cnt_d[i];
      end
      full_q <= fifo_full_h;
      oe_q <= ssd_oe;
      ast_q <= ast_d;
      grant_q <= grant_d;
      gidx_q <= gidx_d;
      ptr_q <= ptr_d;
    end
  end
  assign ssd_oe_out = oe_q;
  assign grant = grant_q;
  assign grant_valid = |grant_q;
endmodule

// File: tb/tb_ssd_ready_arb.sv
// tb_ssd_ready_arb: directed and randomized checks of ssd_ready_arb against a behavioural model
module tb_ssd_ready_arb;
  localparam int CH = 4;
  localparam int LW = 11;
  localparam int HOLD = 16;
  logic clk = 0;
  logic reset_n = 0;
  logic xfer_done = 0;
  logic [CH*LW-1:0] fifo_level = '0;
  logic [CH-1:0] fifo_full_h = '0;
  logic [CH-1:0] ssd_oe = '0;
  logic [CH-1:0] ssd_oe_out, ssd_ready, grant;
  logic grant_valid;
  int checks = 0;
  int failures = 0;
  ssd_ready_arb #(.CH(CH), .LW(LW), .HI_TH(1000), .LO_TH(768), .HOLD(HOLD), .HW(8)) dut (
    .clk(clk), .reset_n(reset_n), .fifo_level(fifo_level), .fifo_full_h(fifo_full_h),
    .ssd_oe(ssd_oe), .xfer_done(xfer_done), .ssd_oe_out(ssd_oe_out), .ssd_ready(ssd_ready),
    .grant(grant), .grant_valid(grant_valid)
  );
  always #5 clk = ~clk;
  int m_lvl [CH];
  int m_wait [CH];
  bit [CH-1:0] m_full, m_oe, m_rdy;
  int m_g = -1;
  int m_ptr = 0;
  bit m_gap = 0;
  logic [CH-1:0] m_gnt = '0;
  always @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < CH; i++) begin
        m_lvl[i] = 0;
        m_wait[i] = 0;
      end
      m_full = '0; m_oe = '0; m_rdy = '0;
      m_g = -1; m_ptr = 0; m_gap = 0;
    end else begin
      if (m_gap) m_gap = 0;
      else if (m_g >= 0) begin
        if (xfer_done || !m_rdy[m_g]) begin
          m_ptr = (m_g + 1) % CH;
          m_g = -1;
          m_gap = 1;
        end
      end else begin
        for (int j = 0; j < CH; j++)
          if (m_g < 0 && m_rdy[(m_ptr + j) % CH]) m_g = (m_ptr + j) % CH;
      end
      for (int i = 0; i < CH; i++) begin
        if (m_rdy[i]) begin
          if (!m_oe[i] || m_full[i] || m_lvl[i] >= 1000) begin
            m_rdy[i] = 0;
            m_wait[i] = HOLD;
          end
        end else if (m_wait[i] > 0) m_wait[i]--;
        else if (m_oe[i] && !m_full[i] && m_lvl[i] <= 768) m_rdy[i] = 1;
      end
      for (int i = 0; i < CH; i++) m_lvl[i] = int'(fifo_level[i*LW +: LW]);
      m_full = fifo_full_h;
      m_oe = ssd_oe;
    end
    m_gnt = (m_g < 0) ? '0 : CH'(1) << m_g;
  end
  task automatic drive_all(input logic [CH-1:0] oe, input int lvl);
    ssd_oe = oe;
    fifo_full_h = '0;
    for (int i = 0; i < CH; i++) fifo_level[i*LW +: LW] = LW'(lvl);
  endtask
  task automatic test_reset;
    reset_n = 0;
    xfer_done = 0;
    drive_all('1, 0);
    repeat (2) @(negedge clk);
    checks++;
    if ({ssd_oe_out, ssd_ready, grant, grant_valid} !== '0) begin
      failures++;
      $display("FAIL reset: oe/rdy/gnt/gv=%h/%h/%h/%b required all 0", ssd_oe_out, ssd_ready, grant, grant_valid);
    end
  endtask
  task automatic test_startup;
    reset_n = 1;
    @(negedge clk);
    checks++;
    if (ssd_ready !== 4'b0000 || ssd_oe_out !== 4'b1111) begin
      failures++;
      $display("FAIL startup_e1: rdy=%b oe_out=%b required 0000/1111", ssd_ready, ssd_oe_out);
    end
    @(negedge clk);
    checks++;
    if (ssd_ready !== 4'b1111 || grant !== 4'b0000) begin
      failures++;
      $display("FAIL startup_e2: rdy=%b gnt=%b required 1111/0000", ssd_ready, grant);
    end
    @(negedge clk);
    checks++;
    if (grant !== 4'b0001 || grant_valid !== 1'b1) begin
      failures++;
      $display("FAIL startup_e3: gnt=%b gv=%b required 0001/1", grant, grant_valid);
    end
  endtask
  task automatic test_hysteresis;
    int n;
    fifo_level[0 +: LW] = 11'd1000;
    n = 0;
    do begin @(negedge clk); n++; end while (ssd_ready[0] && n < 10);
    checks++;
    if (n != 2) begin
      failures++;
      $display("FAIL hyst_fall: cycles=%0d required 2", n);
    end
    n = 0;
    do begin
      fifo_level[0 +: LW] = (n < 5) ? 11'd900 : 11'd768;
      @(negedge clk);
      n++;
    end while (!ssd_ready[0] && n < 60);
    checks++;
    if (n != HOLD + 1) begin
      failures++;
      $display("FAIL hyst_off_time: cycles=%0d required %0d", n, HOLD + 1);
    end
  endtask
  task automatic test_full_pulse;
    int n;
    fifo_level[2*LW +: LW] = 11'd10;
    repeat (3) @(negedge clk);
    fifo_full_h[2] = 1'b1;
    @(negedge clk);
    fifo_full_h[2] = 1'b0;
    n = 1;
    while (ssd_ready[2] && n < 10) begin @(negedge clk); n++; end
    checks++;
    if (n != 2) begin
      failures++;
      $display("FAIL full_fall: cycles=%0d required 2", n);
    end
    n = 0;
    do begin @(negedge clk); n++; end while (!ssd_ready[2] && n < 60);
    checks++;
    if (n != HOLD + 1) begin
      failures++;
      $display("FAIL full_low_time: cycles=%0d required %0d", n, HOLD + 1);
    end
  endtask
  task automatic test_round_robin;
    logic [CH-1:0] prev, exp;
    logic [CH-1:0] seq [5];
    int k;
    bit no_gap;
    reset_n = 0;
    drive_all('1, 0);
    @(negedge clk);
    reset_n = 1;
    prev = '0; k = 0; no_gap = 0;
    for (int c = 0; c < 60; c++) begin
      xfer_done = (c % 5 == 4);
      @(negedge clk);
      checks++;
      if ({ssd_oe_out, ssd_ready, grant, grant_valid} !== {m_oe, m_rdy, m_gnt, |m_gnt} || $countones(grant) > 1) begin
        failures++;
        $display("FAIL rr_model c=%0d: rdy/gnt/gv=%b/%b/%b required %b/%b/%b", c, ssd_ready, grant, grant_valid, m_rdy, m_gnt, |m_gnt);
      end
      if (grant !== '0 && grant !== prev) begin
        if (prev !== '0) no_gap = 1;
        if (k < 5) begin seq[k] = grant; k++; end
      end
      prev = grant;
    end
    xfer_done = 0;
    checks++;
    if (no_gap || k != 5) begin
      failures++;
      $display("FAIL rr_gap: missing_gap=%b grants_seen=%0d required 0/5", no_gap, k);
    end
    for (int i = 0; i < k; i++) begin
      exp = CH'(1) << (i % CH);
      checks++;
      if (seq[i] !== exp) begin
        failures++;
        $display("FAIL rr_seq[%0d]: grant=%b required %b", i, seq[i], exp);
      end
    end
  endtask
  task automatic test_release_collision;
    int n;
    reset_n = 0;
    drive_all('1, 0);
    @(negedge clk);
    reset_n = 1;
    repeat (3) @(negedge clk);
    xfer_done = 1;
    @(negedge clk);
    xfer_done = 0;
    n = 0;
    while (grant !== 4'b0010 && n < 8) begin @(negedge clk); n++; end
    checks++;
    if (grant !== 4'b0010) begin
      failures++;
      $display("FAIL coll_setup: grant=%b required 0010", grant);
    end
    ssd_oe[1] = 1'b0;
    repeat (2) @(negedge clk);
    xfer_done = 1;
    @(negedge clk);
    xfer_done = 0;
    checks++;
    if (grant !== 4'b0000 || ssd_ready[1] !== 1'b0) begin
      failures++;
      $display("FAIL coll_release: grant=%b rdy1=%b required 0000/0", grant, ssd_ready[1]);
    end
    n = 0;
    while (grant === '0 && n < 8) begin @(negedge clk); n++; end
    checks++;
    if (grant !== 4'b0100 || n != 2) begin
      failures++;
      $display("FAIL coll_next: grant=%b after %0d cycles required 0100 after 2", grant, n);
    end
    ssd_oe = '1;
  endtask
  task automatic test_reset_mid;
    int n;
    fifo_full_h[3] = 1'b1;
    @(negedge clk);
    fifo_full_h[3] = 1'b0;
    repeat (3) @(negedge clk);
    n = 0;
    while (!grant_valid && n < 10) begin @(negedge clk); n++; end
    checks++;
    if (!grant_valid || ssd_ready[3] !== 1'b0) begin
      failures++;
      $display("FAIL rmid_setup: gv=%b rdy3=%b required 1/0", grant_valid, ssd_ready[3]);
    end
    reset_n = 0;
    @(negedge clk);
    checks++;
    if ({ssd_oe_out, ssd_ready, grant, grant_valid} !== '0) begin
      failures++;
      $display("FAIL rmid_clear: oe/rdy/gnt/gv=%h/%h/%h/%b required all 0", ssd_oe_out, ssd_ready, grant, grant_valid);
    end
    test_startup();
  endtask
  task automatic test_random;
    for (int c = 0; c < 3000; c++) begin
      reset_n = ($urandom_range(0, 499) != 0);
      for (int i = 0; i < CH; i++) begin
        if ($urandom_range(0, 5) == 0) fifo_level[i*LW +: LW] = LW'($urandom_range(600, 1100));
        fifo_full_h[i] = ($urandom_range(0, 40) == 0);
        ssd_oe[i] = ($urandom_range(0, 15) != 0);
      end
      xfer_done = ($urandom_range(0, 5) == 0);
      @(negedge clk);
      checks++;
      if ({ssd_oe_out, ssd_ready, grant, grant_valid} !== {m_oe, m_rdy, m_gnt, |m_gnt} || $countones(grant) > 1) begin
        failures++;
        $display("FAIL rand c=%0d: oe/rdy/gnt/gv=%b/%b/%b/%b required %b/%b/%b/%b", c, ssd_oe_out, ssd_ready, grant, grant_valid, m_oe, m_rdy, m_gnt, |m_gnt);
      end
    end
    reset_n = 1;
    xfer_done = 0;
  endtask
  initial begin
    test_reset();
    test_startup();
    test_hysteresis();
    test_full_pulse();
    test_round_robin();
    test_release_collision();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ssd_ready_arb.md
# ssd_ready_arb

Multi-channel successor to the single-channel SSD ready controller. For `CH` SSD write channels it:
- registers each channel's FIFO status and output-enable;
- drives a per-channel `ssd_ready` with level-based hysteresis and a minimum off-time;
- round-robin grants the shared SSD data bus to one ready channel at a time, with a release handshake.

It sits between the per-channel write FIFOs and the SSD bus sequencer.

## Interface
Parameters:
- CH, 4, number of channels (2..16)
- LW, 11, FIFO level width per channel
- HI_TH, 1000, level at or above which ready drops (must be > LO_TH)
- LO_TH, 768, level at or below which ready may re-assert
- HOLD, 16, minimum off-time in cycles after ready drops (0 = none)
- HW, 8, hold counter width (2^HW > HOLD)

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset_n  in  1  synchronous, active-low reset
- fifo_level  in  CH*LW  per-channel FIFO fill level, channel i at [i*LW +: LW]
- fifo_full_h  in  CH  per-channel hard full flag
- ssd_oe  in  CH  per-channel SSD output enable
- xfer_done  in  1  bus sequencer pulse: current granted transfer finished
- ssd_oe_out  out  CH  registered copy of ssd_oe
- ssd_ready  out  CH  per-channel ready
- grant  out  CH  one-hot bus grant, all-zero when none
- grant_valid  out  1  high when grant is non-zero

## Operation
**Reset.** Reset_n low at a rising edge clears all registers:
- outputs ssd_oe_out, ssd_ready, grant, grant_valid = 0;
- all channel FSMs go to OFF;
- round-robin pointer = 0.

Reset mid-grant aborts the grant with no release gap.

**Stage 1, every cycle, per channel.** Register fifo_level into level_r, fifo_full_h into full_r, and ssd_oe into ssd_oe_out.

**Stage 2, per-channel FSM.**
- OFF: ready = 0. Goes to ON when ssd_oe_out && !full_r && level_r <= LO_TH.
- ON: ready = 1. Leaves when !ssd_oe_out || full_r || level_r >= HI_TH:
  - HOLD > 0: go to HOLD, load counter with HOLD-1;
  - HOLD = 0: go to OFF.
- HOLD: ready = 0. Counter decrements each cycle. At count 0 go to OFF, ignoring inputs until then.
- Level strictly between LO_TH and HI_TH: state is unchanged (hysteresis).
- ssd_ready is the registered FSM output (1 in ON only).

**Arbiter.**
- IDLE (grant_valid = 0): if any ssd_ready bit is set, pick the first set bit at index >= pointer, wrapping from CH-1 to 0. Grant it on the next edge.
- GRANTED: hold grant until release. Release is xfer_done = 1, or ssd_ready of the granted channel = 0.
- On release:
  - grant and grant_valid go to 0 on the next edge;
  - pointer = granted index + 1 mod CH;
  - arbiter spends exactly one cycle in GAP before returning to IDLE.
- xfer_done and ready-drop in the same cycle count as one release.
- xfer_done while not granted is ignored.
- grant is always one-hot or zero.

## Timing
- Input change sampled at edge k → stage 1 at edge k+1 → ssd_ready change at edge k+2, a fixed 2-cycle latency.
- ssd_oe_out lags ssd_oe by 1 cycle.
- A drop sampled in stage 1 at edge k+1 clears ssd_ready at edge k+2. ssd_ready can reassert no earlier than edge k+2+HOLD+1: HOLD cycles in HOLD, then one cycle in OFF.
- Grant latency: first ready bit set at edge m → grant at edge m+1.
- Release latency: release seen at edge r → grant cleared at edge r+1 → earliest new grant at edge r+3 (cycle r+2 is the GAP).
- The bus sequencer must not assume grant persists after ssd_ready of its channel falls.

## Test plan
- Reset, then CH=4, all oe = 1, levels = 0, full = 0 → all ssd_ready = 1 two cycles after reset release; grant = 4'b0001 one cycle later.
- Ch0 level ramps 0→1000 → ssd_ready[0] falls 2 cycles after level hits 1000; level back to 900 → stays 0; level 768 → rises after HOLD expiry plus 2-cycle latency, no earlier than 17 cycles after the fall.
- fifo_full_h[2] pulses 1 for one cycle with level 10 → ssd_ready[2] low for exactly HOLD+1 = 17 cycles, then 1 again.
- All channels ready, xfer_done every 5 cycles → grant sequence 0001, 0010, 0100, 1000, 0001 with a 1-cycle zero gap between grants; grant never multi-hot.
- Granted ch1 loses oe in the same cycle as xfer_done → single release, pointer = 2, next grant = 0100.
- Reset_n low for one cycle while granted and in HOLD → all outputs 0 at next edge; normal restart follows.
